// File: rtl/hit_detector.sv
// hit_detector
// Collision detector on the pixel-stream side of the enemy sprite drawers.
// Each Clk during a frame it compares every live enemy's sprite pixel with the
// player missile pixel. At the first overlap of a frame it latches the lowest
// overlapping enemy. At the next frame boundary it commits that enemy as the
// frame's hit, then holds it for one full frame. It also tracks the alive mask
// and the score, and it flags when the wave has been cleared.
//
// Ports
//   Clk              pixel/system clock
//   Reset            asynchronous, active-high reset
//   frame_clk        vsync-derived frame tick, asynchronous to Clk
//   start            new-game pulse
//   is_playing       game-running level
//   enemy_on         per-enemy sprite pixel active this Clk
//   missile_on       missile sprite pixel active this Clk
//   hit              per-enemy hit, held for one full frame
//   missile_consumed 1-Clk pulse while a hit is committing
//   alive            enemies not yet destroyed
//   score            accumulated score, saturating
//   all_cleared      wave cleared while playing
module hit_detector #(
  parameter int unsigned NUM_ENEMIES = 8,
  parameter int unsigned POINTS      = 10,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   start,
  input  logic                   is_playing,
  input  logic [NUM_ENEMIES-1:0] enemy_on,
  input  logic                   missile_on,
  output logic [NUM_ENEMIES-1:0] hit,
  output logic                   missile_consumed,
  output logic [NUM_ENEMIES-1:0] alive,
  output logic [SCORE_W-1:0]     score,
  output logic                   all_cleared
);

  // The score sum is formed in a wider word so that saturation can be detected.
  localparam int unsigned SUM_W = SCORE_W + 32;
  localparam logic [NUM_ENEMIES-1:0] ALL_ALIVE = '1;
  localparam logic [SCORE_W-1:0]     SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_CLEARED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   edge_q, edge_d;
  logic [NUM_ENEMIES-1:0] pending_q, pending_d;
  logic [NUM_ENEMIES-1:0] hit_q, hit_d;
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   consumed_q, consumed_d;
  logic                   cleared_q, cleared_d;

  logic                   frame_tick_c;
  logic [NUM_ENEMIES-1:0] ov_c;
  logic [NUM_ENEMIES-1:0] first_c;
  logic [NUM_ENEMIES-1:0] alive_after_c;
  logic [SUM_W-1:0]       score_sum_c;
  logic [SCORE_W-1:0]     score_inc_c;

  // frame_clk synchroniser and rising-edge detect
  always_comb begin
    sync1_d      = frame_clk;
    sync2_d      = sync1_q;
    edge_d       = sync2_q;
    frame_tick_c = sync2_q & ~edge_q;
  end

  // Overlap of live enemies with the missile. x & -x keeps the lowest set bit.
  always_comb begin
    ov_c          = enemy_on & alive_q & {NUM_ENEMIES{missile_on}};
    first_c       = ov_c & (~ov_c + NUM_ENEMIES'(1));
    alive_after_c = alive_q & ~pending_q;
    score_sum_c   = SUM_W'(score_q) + SUM_W'(POINTS);
    score_inc_c   = (score_sum_c > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                      : score_sum_c[SCORE_W-1:0];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    hit_d      = hit_q;
    alive_d    = alive_q;
    score_d    = score_q;
    consumed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hit_d     = '0;
        pending_d = '0;
        if (start) begin
          state_d = ST_SCAN;
          score_d = '0;
          alive_d = ALL_ALIVE;
        end
      end

      ST_SCAN: begin
        // The first overlap of the frame is frozen until it commits.
        if (pending_q == '0) begin
          pending_d = first_c;
        end
        if (frame_tick_c) begin
          state_d = ST_COMMIT;
          // Raised on entry so that the registered pulse lines up with COMMIT.
          consumed_d = (pending_d != '0);
        end
      end

      ST_COMMIT: begin
        hit_d     = pending_q;
        alive_d   = alive_after_c;
        pending_d = '0;
        if (pending_q != '0) begin
          score_d = score_inc_c;
        end
        state_d = (alive_after_c == '0) ? ST_CLEARED : ST_SCAN;
      end

      ST_CLEARED: begin
        pending_d = '0;
        if (frame_tick_c) begin
          hit_d = '0;
        end
        if (start) begin
          state_d = ST_SCAN;
          hit_d   = '0;
          score_d = '0;
          alive_d = ALL_ALIVE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        hit_d     = '0;
        pending_d = '0;
      end
    endcase

    // Leaving play keeps the score and alive mask for display.
    if ((state_q != ST_IDLE) && !is_playing) begin
      state_d    = ST_IDLE;
      hit_d      = '0;
      pending_d  = '0;
      alive_d    = alive_q;
      score_d    = score_q;
      consumed_d = 1'b0;
    end else if (start && ((state_q == ST_SCAN) || (state_q == ST_COMMIT))) begin
      // A restart takes priority over a frame tick that arrives in the same Clk.
      state_d    = ST_SCAN;
      hit_d      = '0;
      pending_d  = '0;
      alive_d    = ALL_ALIVE;
      score_d    = '0;
      consumed_d = 1'b0;
    end

    cleared_d = (state_d == ST_CLEARED);
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      pending_q  <= '0;
      hit_q      <= '0;
      alive_q    <= ALL_ALIVE;
      score_q    <= '0;
      consumed_q <= 1'b0;
      cleared_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      pending_q  <= pending_d;
      hit_q      <= hit_d;
      alive_q    <= alive_d;
      score_q    <= score_d;
      consumed_q <= consumed_d;
      cleared_q  <= cleared_d;
    end
  end

  assign hit              = hit_q;
  assign missile_consumed = consumed_q;
  assign alive            = alive_q;
  assign score            = score_q;
  assign all_cleared      = cleared_q;

endmodule

// File: tb/tb_hit_detector.sv
module tb_hit_detector;

  typedef struct packed {
    logic [7:0]  hit;
    logic [7:0]  alive;
    logic [15:0] score;
    logic [3:0]  sat_score;
    logic [3:0]  pulses;
    logic        cleared;
  } obs_t;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start, is_playing, missile_on;
  logic [7:0]  enemy_on;

  logic [7:0]  hit, alive;
  logic        missile_consumed, all_cleared;
  logic [15:0] score;

  logic [7:0]  hit_s, alive_s;
  logic        consumed_s, cleared_s;
  logic [3:0]  score_s;

  int   compared   = 0;
  int   mismatched = 0;
  obs_t exp_q[$];

  always #5 Clk = ~Clk;

  hit_detector dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .is_playing(is_playing), .enemy_on(enemy_on), .missile_on(missile_on),
    .hit(hit), .missile_consumed(missile_consumed), .alive(alive),
    .score(score), .all_cleared(all_cleared)
  );

  hit_detector #(.NUM_ENEMIES(8), .POINTS(10), .SCORE_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .is_playing(is_playing), .enemy_on(enemy_on), .missile_on(missile_on),
    .hit(hit_s), .missile_consumed(consumed_s), .alive(alive_s),
    .score(score_s), .all_cleared(cleared_s)
  );

  function automatic obs_t mk(input logic [7:0] h, input logic [7:0] a,
                              input int sc, input int sat, input int p,
                              input logic c);
    obs_t o;
    o.hit = h; o.alive = a; o.score = 16'(sc); o.sat_score = 4'(sat);
    o.pulses = 4'(p); o.cleared = c;
    return o;
  endfunction

  function automatic obs_t sample(input int p);
    return mk(hit, alive, int'(score), int'(score_s), p, all_cleared);
  endfunction

  task automatic pulse_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
  endtask

  task automatic overlap(input logic [7:0] m, input int cycles);
    @(negedge Clk); enemy_on = m; missile_on = 1'b1;
    repeat (cycles) @(negedge Clk);
    enemy_on = '0; missile_on = 1'b0;
  endtask

  // One frame_clk period; counts missile_consumed pulses seen on the way.
  task automatic do_frame(output int pulses);
    pulses = 0;
    @(negedge Clk); frame_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (missile_consumed) pulses++;
    end
    frame_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (missile_consumed) pulses++;
    end
  endtask

  task automatic test_reset();
    int p;
    obs_t o, e;
    compared++;
    if ({hit, alive, score, missile_consumed, all_cleared, score_s} !==
        {8'h00, 8'hFF, 16'd0, 1'b0, 1'b0, 4'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got hit=%h alive=%h score=%0d mc=%b clr=%b, want 00 ff 0 0 0",
               hit, alive, score, missile_consumed, all_cleared);
    end
    // Reset in the middle of a frame with enemy 1 pending.
    pulse_start();
    overlap(8'h02, 2);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    compared++;
    if ({hit, alive, score, missile_consumed, all_cleared} !==
        {8'h00, 8'hFF, 16'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_scan: got hit=%h alive=%h score=%0d mc=%b clr=%b, want 00 ff 0 0 0",
               hit, alive, score, missile_consumed, all_cleared);
    end
    // Back in IDLE: the discarded pending overlap must never commit.
    exp_q.push_back(mk(8'h00, 8'hFF, 0, 0, 0, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL reset_idle_frame: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  task automatic test_single_hit();
    int p;
    obs_t o, e;
    pulse_start();
    overlap(8'h04, 5);
    exp_q.push_back(mk(8'h04, 8'hFB, 10, 10, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL single_hit: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    // The dead enemy is masked, so it cannot be hit again.
    overlap(8'h04, 3);
    compared++;
    if (hit !== 8'h04) begin
      mismatched++;
      $display("FAIL single_hit_held: got hit=%h want 04", hit);
    end
    exp_q.push_back(mk(8'h00, 8'hFB, 10, 10, 0, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL single_hit_next_frame: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  task automatic test_same_clk();
    int p;
    obs_t o, e;
    pulse_start();
    overlap(8'h28, 1);
    exp_q.push_back(mk(8'h08, 8'hF7, 10, 10, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL same_clk: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  task automatic test_first_wins();
    int p;
    obs_t o, e;
    pulse_start();
    overlap(8'h02, 1);
    repeat (80) @(negedge Clk);
    overlap(8'h40, 1);
    exp_q.push_back(mk(8'h02, 8'hFD, 10, 10, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL first_wins: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    overlap(8'h40, 2);
    exp_q.push_back(mk(8'h40, 8'hBD, 20, 15, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL first_wins_next: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  // An overlap in the tick Clk is taken; an overlap during COMMIT is dropped.
  task automatic test_overlap_at_tick();
    int p;
    obs_t o, e;
    pulse_start();
    p = 0;
    exp_q.push_back(mk(8'h10, 8'hEF, 10, 10, 1, 1'b0));
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk); enemy_on = 8'h10; missile_on = 1'b1;
    @(negedge Clk);
    if (missile_consumed) p++;
    compared++;
    if (missile_consumed !== 1'b1) begin
      mismatched++;
      $display("FAIL tick_consumed_on: got %b want 1", missile_consumed);
    end
    enemy_on = 8'h01;
    @(negedge Clk);
    enemy_on = '0; missile_on = 1'b0;
    compared++;
    if (missile_consumed !== 1'b0) begin
      mismatched++;
      $display("FAIL tick_consumed_off: got %b want 0", missile_consumed);
    end
    frame_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (missile_consumed) p++;
    end
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL overlap_at_tick: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    exp_q.push_back(mk(8'h00, 8'hEF, 10, 10, 0, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL commit_overlap_dropped: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    obs_t o, e;
    logic [7:0] a;
    logic [7:0] m;
    a = 8'hFF;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      m = 8'h01 << i;
      a = a & ~m;
      overlap(m, 2);
      exp_q.push_back(mk(m, a, 10 * (i + 1), (i == 0) ? 10 : 15, 1, i == 7));
      do_frame(p);
      o = sample(p); e = exp_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL clear_all_%0d: got %h want %h (hit,alive,score,sat,pulses,clr)", i, o, e);
      end
    end
    exp_q.push_back(mk(8'h00, 8'h00, 80, 15, 0, 1'b1));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL cleared_hit_drop: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
  endtask

  task automatic test_saturation();
    int p;
    obs_t o, e;
    pulse_start();
    overlap(8'h08, 1);
    exp_q.push_back(mk(8'h08, 8'hF7, 10, 10, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL sat_first: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    overlap(8'h10, 1);
    exp_q.push_back(mk(8'h10, 8'hE7, 20, 15, 1, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL sat_second: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    @(negedge Clk); is_playing = 1'b0;
    repeat (2) @(negedge Clk);
    compared++;
    if ({hit, alive, score, score_s} !== {8'h00, 8'hE7, 16'd20, 4'd15}) begin
      mismatched++;
      $display("FAIL stop_keeps_score: got hit=%h alive=%h score=%0d sat=%0d, want 00 e7 20 15",
               hit, alive, score, score_s);
    end
    overlap(8'h20, 2);
    exp_q.push_back(mk(8'h00, 8'hE7, 20, 15, 0, 1'b0));
    do_frame(p);
    o = sample(p); e = exp_q.pop_front(); compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL idle_ignores_frame: got %h want %h (hit,alive,score,sat,pulses,clr)", o, e);
    end
    is_playing = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; is_playing = 1'b1;
    missile_on = 1'b0; enemy_on = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    test_reset();
    test_single_hit();
    test_same_clk();
    test_first_wins();
    test_overlap_at_tick();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
